// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - CPU load/store unit driving a big-endian word-wide data memory.
// Sub-word stores use read-modify-write; rejected requests complete without touching memory.
module load_store_unit #(
  parameter int ADDR_LIMIT = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic        dm_cs,
  output logic        dm_wr,
  output logic        dm_rd,
  input  logic [31:0] dm_rdata
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  localparam logic [31:0] LAST_WORD = 32'(ADDR_LIMIT - 4);

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] old_q, old_d;
  logic        err_q, err_d;

  logic        accept;
  logic        req_err;
  logic [4:0]  byte_lsb;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] merged;
  logic [31:0] load_val;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      size_q   <= 2'b00;
      signed_q <= 1'b0;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      old_q    <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      old_q    <= old_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    accept  = (state_q == IDLE) && req_valid;
    req_err = (req_size == 2'b11)
           || ((req_size == 2'b01) && req_addr[0])
           || ((req_size == 2'b10) && (req_addr[1:0] != 2'b00))
           || ({req_addr[31:2], 2'b00} > LAST_WORD);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_err)                            state_d = RESP;
          else if (req_we && req_size == 2'b10)   state_d = WRITE;
          else                                    state_d = READ;
        end
      end
      READ:    state_d = we_q ? WRITE : RESP;
      WRITE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request fields are frozen at accept; the old word is sampled on the edge leaving READ.
  always_comb begin
    we_d     = accept ? req_we     : we_q;
    size_d   = accept ? req_size   : size_q;
    signed_d = accept ? req_signed : signed_q;
    addr_d   = accept ? req_addr   : addr_q;
    wdata_d  = accept ? req_wdata  : wdata_q;
    err_d    = accept ? req_err    : err_q;
    old_d    = (state_q == READ) ? dm_rdata : old_q;
  end

  // Big-endian lanes: byte offset 0 lives in bits [31:24].
  always_comb begin
    byte_lsb = {~addr_q[1:0], 3'b000};
    lane_b   = old_q[byte_lsb +: 8];
    lane_h   = addr_q[1] ? old_q[15:0] : old_q[31:16];
    merged   = old_q;
    load_val = old_q;
    case (size_q)
      2'b00: begin
        merged[byte_lsb +: 8] = wdata_q[7:0];
        load_val = {{24{signed_q & lane_b[7]}}, lane_b};
      end
      2'b01: begin
        if (addr_q[1]) merged[15:0]  = wdata_q[15:0];
        else           merged[31:16] = wdata_q[15:0];
        load_val = {{16{signed_q & lane_h[15]}}, lane_h};
      end
      default: merged = wdata_q;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    rsp_rdata = 32'h0;
    dm_addr   = 32'h0;
    dm_wdata  = 32'h0;
    dm_cs     = 1'b0;
    dm_wr     = 1'b0;
    dm_rd     = 1'b0;
    case (state_q)
      IDLE: req_ready = 1'b1;
      READ: begin
        dm_cs   = 1'b1;
        dm_rd   = 1'b1;
        dm_addr = {addr_q[31:2], 2'b00};
      end
      WRITE: begin
        dm_cs    = 1'b1;
        dm_wr    = 1'b1;
        dm_addr  = {addr_q[31:2], 2'b00};
        dm_wdata = merged;
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_err   = err_q;
        rsp_rdata = (err_q || we_q) ? 32'h0 : load_val;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - randomized self-checking bench for load_store_unit.
// A byte-array memory serves the DUT; a second byte array is the reference image.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_cs;
  logic        dm_wr;
  logic        dm_rd;
  logic [31:0] dm_rdata;

  logic [7:0]  mem     [0:4095];
  logic [7:0]  ref_mem [0:4095];

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] r_rd, r_wd;
  logic        r_err;

  load_store_unit #(.ADDR_LIMIT(4096)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_cs(dm_cs), .dm_wr(dm_wr), .dm_rd(dm_rd), .dm_rdata(dm_rdata)
  );

  always #5 clk = ~clk;

  always_comb begin
    dm_rdata = 32'h0;
    if (dm_cs && dm_rd)
      dm_rdata = {mem[dm_addr[11:0]], mem[dm_addr[11:0] + 12'd1],
                  mem[dm_addr[11:0] + 12'd2], mem[dm_addr[11:0] + 12'd3]};
  end

  always @(posedge clk) begin
    if (dm_cs && dm_wr) begin
      mem[dm_addr[11:0]]         <= dm_wdata[31:24];
      mem[dm_addr[11:0] + 12'd1] <= dm_wdata[23:16];
      mem[dm_addr[11:0] + 12'd2] <= dm_wdata[15:8];
      mem[dm_addr[11:0] + 12'd3] <= dm_wdata[7:0];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    int base;
    base = int'(a[11:0]) & ~3;
    return {ref_mem[base], ref_mem[base + 1], ref_mem[base + 2], ref_mem[base + 3]};
  endfunction

  function automatic logic ref_err(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0)
        || ((a / 4) * 4 > 32'd4092);
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic sg, input logic [31:0] a);
    int i;
    logic [7:0]  b;
    logic [15:0] h;
    i = int'(a[11:0]);
    case (sz)
      2'd0: begin
        b = ref_mem[i];
        return sg ? 32'($signed(b)) : 32'(b);
      end
      2'd1: begin
        h = {ref_mem[i], ref_mem[i + 1]};
        return sg ? 32'($signed(h)) : 32'(h);
      end
      default: return {ref_mem[i], ref_mem[i + 1], ref_mem[i + 2], ref_mem[i + 3]};
    endcase
  endfunction

  task automatic ref_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    int i;
    int n;
    i = int'(a[11:0]);
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    for (int k = 0; k < n; k++)
      ref_mem[i + k] = 8'((wd >> (8 * (n - 1 - k))) & 32'hFF);
  endtask

  task automatic run_req(input logic we, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] rd_out, output logic err_out,
                         output logic [31:0] wd_out);
    int edges, rds, wrs, exp_rds, exp_wrs;
    bit got;
    logic e;
    logic [31:0] exp_rd;
    edges = 0; rds = 0; wrs = 0; got = 0;
    rd_out = 32'h0; err_out = 1'b0; wd_out = 32'h0;
    @(negedge clk);
    chk("idle_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    @(posedge clk);
    edges = 1;
    #1;
    req_valid = 1'b0; req_we = 1'($urandom); req_size = 2'($urandom_range(0, 3));
    req_signed = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    while (!got && edges <= 6) begin
      @(negedge clk);
      if (dm_cs && dm_rd) rds++;
      if (dm_cs && dm_wr) begin wrs++; wd_out = dm_wdata; end
      if (rsp_valid) begin
        got = 1; rd_out = rsp_rdata; err_out = rsp_err;
      end else begin
        chk("busy_not_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        edges++;
      end
    end
    chk("rsp_seen", 32'(got), 32'd1);
    e = ref_err(sz, a);
    exp_rds = (!e && (!we || sz != 2'd2)) ? 1 : 0;
    exp_wrs = (!e && we) ? 1 : 0;
    exp_rd = 32'h0;
    if (!e && !we) exp_rd = ref_load(sz, sg, a);
    if (!e && we) ref_store(sz, a, wd);
    chk("rsp_err", 32'(err_out), 32'(e));
    chk("rsp_rdata", rd_out, exp_rd);
    chk("latency", 32'(edges), 32'(1 + exp_rds + exp_wrs));
    chk("read_cycles", 32'(rds), 32'(exp_rds));
    chk("write_cycles", 32'(wrs), 32'(exp_wrs));
    if (exp_wrs == 1) chk("dm_wdata", wd_out, ref_word(a));
    @(negedge clk);
    chk("rsp_one_cycle", 32'(rsp_valid), 32'd0);
    chk("ready_after", 32'(req_ready), 32'd1);
  endtask

  initial begin
    int diffs, pulses, waited;
    bit seen_wr;
    logic [31:0] exp_load;
    logic [31:0] ra;
    logic [1:0]  rs;

    for (int i = 0; i < 4096; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end

    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_dm_cs", 32'(dm_cs), 32'd0);
    chk("rst_dm_wr", 32'(dm_wr), 32'd0);
    chk("rst_dm_addr", dm_addr, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    reset = 1'b0;

    run_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, r_rd, r_err, r_wd);
    chk("word_store_bytes", {mem[16], mem[17], mem[18], mem[19]}, 32'hDEADBEEF);
    run_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, r_rd, r_err, r_wd);
    chk("word_load", r_rd, 32'hDEADBEEF);
    run_req(1'b1, 2'd0, 1'b0, 32'h11, 32'h5A, r_rd, r_err, r_wd);
    chk("byte_merge", r_wd, 32'hDE5ABEEF);
    run_req(1'b1, 2'd0, 1'b0, 32'h11, 32'h80, r_rd, r_err, r_wd);
    run_req(1'b0, 2'd0, 1'b1, 32'h11, 32'h0, r_rd, r_err, r_wd);
    chk("byte_load_signed", r_rd, 32'hFFFFFF80);
    run_req(1'b0, 2'd0, 1'b0, 32'h11, 32'h0, r_rd, r_err, r_wd);
    chk("byte_load_unsigned", r_rd, 32'h00000080);
    run_req(1'b1, 2'd1, 1'b0, 32'h12, 32'h1234, r_rd, r_err, r_wd);
    run_req(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, r_rd, r_err, r_wd);
    chk("half_load_signed", r_rd, 32'h00001234);
    run_req(1'b0, 2'd1, 1'b0, 32'h13, 32'h0, r_rd, r_err, r_wd);
    chk("half_misaligned_err", 32'(r_err), 32'd1);
    run_req(1'b0, 2'd2, 1'b0, 32'hFFC, 32'h0, r_rd, r_err, r_wd);
    chk("last_word_ok", 32'(r_err), 32'd0);
    run_req(1'b0, 2'd2, 1'b0, 32'h1000, 32'h0, r_rd, r_err, r_wd);
    chk("past_limit_err", 32'(r_err), 32'd1);

    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 9))
        0:       ra = $urandom;
        1, 2, 3: ra = 32'($urandom_range(0, 31));
        default: ra = 32'($urandom_range(0, 4103));
      endcase
      run_req(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), ra, $urandom,
              r_rd, r_err, r_wd);
    end

    // Abort a byte store in WRITE: memory and reference must both stay untouched.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_addr = 32'h21; req_wdata = 32'hA5;
    @(posedge clk);
    #1 req_valid = 1'b0;
    seen_wr = 0; waited = 0;
    while (!seen_wr && waited < 5) begin
      @(negedge clk);
      waited++;
      if (dm_wr) seen_wr = 1;
    end
    chk("abort_reached_write", 32'(seen_wr), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("abort_dm_wr", 32'(dm_wr), 32'd0);
    chk("abort_dm_cs", 32'(dm_cs), 32'd0);
    chk("abort_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid) pulses++;
    end
    chk("abort_no_rsp", 32'(pulses), 32'd0);
    chk("abort_mem_word", {mem[32], mem[33], mem[34], mem[35]}, ref_word(32'h20));

    // Held request: a fresh load is accepted every third edge.
    @(negedge clk);
    rs = 2'($urandom_range(0, 2));
    ra = 32'($urandom_range(0, 1000)) * 4;
    exp_load = ref_load(rs, 1'b1, ra);
    req_valid = 1'b1; req_we = 1'b0; req_size = rs; req_signed = 1'b1; req_addr = ra;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("hold_ready", 32'(req_ready), 32'(i % 3 == 2));
      chk("hold_rsp_valid", 32'(rsp_valid), 32'(i % 3 == 1));
      if (rsp_valid) begin
        pulses++;
        chk("hold_rdata", rsp_rdata, exp_load);
      end
    end
    req_valid = 1'b0;
    chk("hold_pulses", 32'(pulses), 32'd4);

    repeat (3) @(negedge clk);
    diffs = 0;
    for (int i = 0; i < 4096; i++)
      if (mem[i] !== ref_mem[i]) diffs++;
    chk("mem_image", 32'(diffs), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
